// File: rtl/rc4_pkg.sv
// Shared RC4 types and constants for the S-array loops (init, key schedule, PRGA).
// Pure declarations: no latency, no flow control.
package rc4_pkg;

    localparam int KEY_BYTES = 3;
    localparam int MEM_DEPTH = 256;

    typedef logic [7:0] byte_t;

    // Read/wait/compute idiom shared with the PRGA loop: each RAM read needs a WAIT slot.
    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WAIT_I,
        CALC_J,
        RD_J,
        WAIT_J,
        GET_J,
        WR_I,
        WR_J,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/key_byte_sel.sv
// Combinational key-byte mux: byte 0 is the most significant byte of the key.
// Zero latency; no flow control.
module key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int KIDX_W    = 2
) (
    input  logic [8*KEY_BYTES-1:0] i_key,
    input  logic [KIDX_W-1:0]      i_idx,
    output byte_t                  o_byte
);

    always_comb begin
        o_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (i_idx == KIDX_W'(k)) begin
                o_byte = i_key[8*(KEY_BYTES-1-k) +: 8];
            end
        end
    end

endmodule

// File: rtl/decrypt_loop_b.sv
// RC4 key-scheduling swap loop over the S RAM; 9 cycles per index, 2304 cycles per run.
// Owns the RAM while start is high; start is only sampled in IDLE and DONE.
module decrypt_loop_b
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = rc4_pkg::KEY_BYTES,
    parameter int MEM_DEPTH = rc4_pkg::MEM_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             q,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wren,
    output logic                   finished
);

    localparam int                KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam byte_t             LAST_I = byte_t'(MEM_DEPTH - 1);
    localparam logic [KIDX_W-1:0] LAST_K = KIDX_W'(KEY_BYTES - 1);

    state_t            r_state, w_state;
    byte_t             r_i, w_i;
    byte_t             r_j, w_j;
    byte_t             r_si, w_si;
    byte_t             r_sj, w_sj;
    logic [KIDX_W-1:0] r_kidx, w_kidx;
    byte_t             r_address, w_address;
    byte_t             r_data, w_data;
    logic              r_wren, w_wren;
    logic              r_finished, w_finished;
    byte_t             w_key;

    // r_kidx tracks i mod KEY_BYTES so no divider is needed.
    key_byte_sel #(
        .KEY_BYTES (KEY_BYTES),
        .KIDX_W    (KIDX_W)
    ) u_key_sel (
        .i_key  (secret_key),
        .i_idx  (r_kidx),
        .o_byte (w_key)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_si       <= '0;
            r_sj       <= '0;
            r_kidx     <= '0;
            r_address  <= '0;
            r_data     <= '0;
            r_wren     <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_i        <= w_i;
            r_j        <= w_j;
            r_si       <= w_si;
            r_sj       <= w_sj;
            r_kidx     <= w_kidx;
            r_address  <= w_address;
            r_data     <= w_data;
            r_wren     <= w_wren;
            r_finished <= w_finished;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_i        = r_i;
        w_j        = r_j;
        w_si       = r_si;
        w_sj       = r_sj;
        w_kidx     = r_kidx;
        w_address  = r_address;
        w_data     = r_data;
        w_wren     = 1'b0;
        w_finished = r_finished;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_i     = '0;
                    w_j     = '0;
                    w_kidx  = '0;
                    w_state = RD_I;
                end
            end
            RD_I: begin
                w_address = r_i;
                w_state   = WAIT_I;
            end
            WAIT_I: begin
                w_state = CALC_J;
            end
            CALC_J: begin
                w_si    = q;
                w_j     = r_j + q + w_key;
                w_state = RD_J;
            end
            RD_J: begin
                w_address = r_j;
                w_state   = WAIT_J;
            end
            WAIT_J: begin
                w_state = GET_J;
            end
            GET_J: begin
                w_sj    = q;
                w_state = WR_I;
            end
            // i==j needs no special case: both writes store the same byte.
            WR_I: begin
                w_address = r_i;
                w_data    = r_sj;
                w_wren    = 1'b1;
                w_state   = WR_J;
            end
            WR_J: begin
                w_address = r_j;
                w_data    = r_si;
                w_wren    = 1'b1;
                w_state   = NEXT;
            end
            NEXT: begin
                if (r_i == LAST_I) begin
                    w_state = DONE;
                end else begin
                    w_i     = r_i + 8'd1;
                    w_kidx  = (r_kidx == LAST_K) ? '0 : r_kidx + 1'b1;
                    w_state = RD_I;
                end
            end
            DONE: begin
                w_finished = 1'b1;
                if (!start) begin
                    w_finished = 1'b0;
                    w_state    = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign address  = r_address;
    assign data     = r_data;
    assign wren     = r_wren;
    assign finished = r_finished;

endmodule

// File: tb/tb_decrypt_loop_b.sv
// Bench for decrypt_loop_b: behavioural S RAM, software KSA reference, write-pair table.
module tb_decrypt_loop_b;
    import rc4_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [23:0] secret_key = '0;
    logic [7:0]  q;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic        finished;

    int total = 0;
    int bad   = 0;

    decrypt_loop_b dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .q          (q),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .finished   (finished)
    );

    always #5 clock = ~clock;

    // RAM with registered address; prep reloads identity and clears the write log.
    logic [7:0] mem [256];
    logic [7:0] ram_addr = '0;
    logic [7:0] wa [1024];
    logic [7:0] wd [1024];
    int         wr_cnt = 0;
    logic       prep = 1'b0;

    always @(posedge clock) begin
        ram_addr <= address;
        if (prep) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
            wr_cnt <= 0;
        end else if (wren) begin
            mem[address] <= data;
            if (wr_cnt < 1024) begin
                wa[wr_cnt] <= address;
                wd[wr_cnt] <= data;
            end
            wr_cnt <= wr_cnt + 1;
        end
    end

    assign q = mem[ram_addr];

    int ref_s [256];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compute_ref(input logic [23:0] key);
        int j;
        int t;
        logic [7:0] kb;
        j = 0;
        for (int k = 0; k < 256; k++) ref_s[k] = k;
        for (int i = 0; i < 256; i++) begin
            kb = key[8*(2 - (i % 3)) +: 8];
            j = (j + ref_s[i] + int'(kb)) % 256;
            t = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
        end
    endtask

    task automatic check_final(input string name, input logic [23:0] key);
        int mism;
        compute_ref(key);
        mism = 0;
        for (int k = 0; k < 256; k++) if (int'(mem[k]) != ref_s[k]) mism++;
        chk(name, mism, 0);
    endtask

    task automatic wait_finish(input int start_edges, output int edges);
        edges = start_edges;
        while (!finished && edges < 3000) begin
            @(negedge clock);
            edges++;
        end
    endtask

    task automatic do_run(input logic [23:0] key);
        int edges;
        prep       = 1'b1;
        secret_key = key;
        @(negedge clock);
        prep  = 1'b0;
        start = 1'b1;
        @(negedge clock);
        chk("run_start_state", int'(dut.r_state), int'(RD_I));
        chk("run_start_i", int'(dut.r_i), 0);
        chk("run_start_j", int'(dut.r_j), 0);
        wait_finish(0, edges);
        chk("run_finish_latency", edges, 2305);
        chk("run_write_count", wr_cnt, 512);
        check_final("run_final_S_mismatches", key);
        start = 1'b0;
        @(negedge clock);
        chk("run_finished_drop", int'(finished), 0);
        chk("run_back_idle", int'(dut.r_state), int'(IDLE));
    endtask

    typedef struct {
        logic [23:0] key;
        int          iter;
        int          a0;
        int          d0;
        int          a1;
        int          d1;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          edges;
        int          found;
        int          n;
        logic [23:0] last_key;

        vecs[0] = '{24'h000000, 0, 0, 0, 0, 0};
        vecs[1] = '{24'h000000, 1, 1, 1, 1, 1};
        vecs[2] = '{24'h000000, 2, 2, 3, 3, 2};
        vecs[3] = '{24'h000000, 3, 3, 5, 5, 2};
        vecs[4] = '{24'h010000, 0, 0, 1, 1, 0};
        vecs[5] = '{24'h010000, 1, 1, 0, 1, 0};
        vecs[6] = '{24'h010000, 2, 2, 3, 3, 2};
        vecs[7] = '{24'h010000, 3, 3, 6, 6, 2};

        // Reset held with start high.
        reset      = 1'b0;
        start      = 1'b1;
        secret_key = 24'h000000;
        prep       = 1'b1;
        repeat (3) @(negedge clock);
        prep = 1'b0;
        chk("reset_address", int'(address), 0);
        chk("reset_data", int'(data), 0);
        chk("reset_wren", int'(wren), 0);
        chk("reset_finished", int'(finished), 0);
        chk("reset_state", int'(dut.r_state), int'(IDLE));

        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("first_read_address", int'(address), 0);
        chk("first_read_state", int'(dut.r_state), int'(WAIT_I));
        wait_finish(1, edges);
        chk("zero_key_latency", edges, 2305);
        chk("zero_key_writes", wr_cnt, 512);
        check_final("zero_key_final_S", 24'h000000);

        // Handshake: finished holds while start stays high.
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("hold_finished", int'(finished), 1);
            chk("hold_wren", int'(wren), 0);
        end
        start = 1'b0;
        @(negedge clock);
        chk("drop_start_finished", int'(finished), 0);

        // Write-pair table; the zero-key log is still in place from the run above.
        last_key = 24'h000000;
        for (int e = 0; e < 8; e++) begin
            if (vecs[e].key != last_key) begin
                do_run(vecs[e].key);
                last_key = vecs[e].key;
            end
            chk($sformatf("vec%0d_addr_i", e), int'(wa[2*vecs[e].iter]), vecs[e].a0);
            chk($sformatf("vec%0d_data_i", e), int'(wd[2*vecs[e].iter]), vecs[e].d0);
            chk($sformatf("vec%0d_addr_j", e), int'(wa[2*vecs[e].iter+1]), vecs[e].a1);
            chk($sformatf("vec%0d_data_j", e), int'(wd[2*vecs[e].iter+1]), vecs[e].d1);
        end

        do_run(24'h000249);

        // Reset during WR_J of iteration 100.
        prep       = 1'b1;
        secret_key = 24'h000249;
        @(negedge clock);
        prep  = 1'b0;
        start = 1'b1;
        found = 0;
        n     = 0;
        while (found == 0 && n < 1500) begin
            @(negedge clock);
            n++;
            if (dut.r_state == WR_J && dut.r_i == 8'd100) found = 1;
        end
        chk("midrun_reach_wr_j", found, 1);
        reset = 1'b0;
        @(negedge clock);
        chk("midrun_reset_wren", int'(wren), 0);
        chk("midrun_reset_address", int'(address), 0);
        chk("midrun_reset_finished", int'(finished), 0);
        chk("midrun_reset_state", int'(dut.r_state), int'(IDLE));
        reset = 1'b1;
        @(negedge clock);
        chk("restart_state", int'(dut.r_state), int'(RD_I));
        chk("restart_i", int'(dut.r_i), 0);
        chk("restart_j", int'(dut.r_j), 0);
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
